// File: rtl/mem_bus_sequencer.sv
// Memory bus sequencer: runs load/store unit accesses on a valid/ready bus.
// Stores are read-modify-write: the word is read, handed back to the
// load/store unit for merging, and the merged word is written.
module mem_bus_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we_in,
  input  logic        fault_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic [31:0] rdata_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } state_t;

  // A phase times out on the cycle its wait counter would reach TIMEOUT.
  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            is_store_q, is_store_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_hit;

  assign to_hit    = TO_EN && (to_cnt_q == TO_LAST);
  assign rdata_out = rdata_q;

  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_store_q <= is_store_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Next-state logic: sequences read, merge and write phases with timeout.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_store_d = is_store_q;
    err_d      = err_q;
    to_cnt_d   = to_cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (fault_in) begin
            state_d = FAULT;
          end else begin
            addr_d     = addr_in;
            is_store_d = we_in;
            err_d      = 1'b0;
            to_cnt_d   = '0;
            state_d    = READ;
          end
        end
      end
      READ: begin
        if (bus_ready) begin
          rdata_d = bus_rdata;
          if (bus_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (is_store_q) begin
            state_d = MERGE;
          end else begin
            state_d = DONE;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_hit) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      MERGE: begin
        wdata_d  = wdata_in;
        to_cnt_d = '0;
        state_d  = WRITE;
      end
      WRITE: begin
        if (bus_ready) begin
          err_d   = bus_err;
          state_d = DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_hit) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; busy is masked by reset so every output is 0 during reset.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state_q)
      IDLE:  busy = req & ~rst;
      READ: begin
        busy      = 1'b1;
        bus_valid = 1'b1;
        bus_addr  = addr_q;
      end
      MERGE: busy = 1'b1;
      WRITE: begin
        busy      = 1'b1;
        bus_valid = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
      end
      DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      FAULT: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Testbench for mem_bus_sequencer: per-cycle vector table plus hand-written
// timeout and reset-during-write sequences.
module tb_mem_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we_in, fault_in;
  logic [31:0] addr_in, wdata_in;
  logic [31:0] rdata_out;
  logic        busy, done, err;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ready, bus_err;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        req, we, flt;
    logic [31:0] addr, wdata;
    logic        rdy;
    logic [31:0] rdata;
    logic        berr;
    logic        e_busy, e_done, e_err, e_valid, e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;
  } vec_t;

  vec_t vecs[$];

  mem_bus_sequencer #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we_in     (we_in),
    .fault_in  (fault_in),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .rdata_out (rdata_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case something never returns.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input string n,
                              input logic r, input logic w, input logic f,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic rd, input logic [31:0] rdat, input logic be,
                              input logic eb, input logic ed, input logic ee,
                              input logic ev, input logic ew,
                              input logic [31:0] ea, input logic [31:0] ewd,
                              input logic [31:0] er);
    vec_t v;
    v.name = n; v.req = r; v.we = w; v.flt = f; v.addr = a; v.wdata = wd;
    v.rdy = rd; v.rdata = rdat; v.berr = be;
    v.e_busy = eb; v.e_done = ed; v.e_err = ee; v.e_valid = ev; v.e_we = ew;
    v.e_addr = ea; v.e_wdata = ewd; v.e_rdata = er;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req       = v.req;
    we_in     = v.we;
    fault_in  = v.flt;
    addr_in   = v.addr;
    wdata_in  = v.wdata;
    bus_ready = v.rdy;
    bus_rdata = v.rdata;
    bus_err   = v.berr;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [100:0] got, exp;
    got = {busy, done, err, bus_valid, bus_we, bus_addr, bus_wdata, rdata_out};
    exp = {v.e_busy, v.e_done, v.e_err, v.e_valid, v.e_we, v.e_addr, v.e_wdata, v.e_rdata};
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got busy=%b done=%b err=%b valid=%b we=%b addr=%h wdata=%h rdata=%h exp busy=%b done=%b err=%b valid=%b we=%b addr=%h wdata=%h rdata=%h",
               v.name, busy, done, err, bus_valid, bus_we, bus_addr, bus_wdata, rdata_out,
               v.e_busy, v.e_done, v.e_err, v.e_valid, v.e_we, v.e_addr, v.e_wdata, v.e_rdata);
    end
  endtask

  task automatic checkValue(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h exp=%h", n, got, exp);
    end
  endtask

  initial begin
    int          valid_cycles;
    int          done_pulses;
    logic        seen_done;
    logic        done_err;
    logic        addr_stable;

    // Load, store RMW, load with wait states, fault, store with read error.
    vecs.push_back(mk("ld_idle",   1,0,0,32'h100,0,          1,32'h55555555,0, 1,0,0,0,0, 0,0,0));
    vecs.push_back(mk("ld_read",   1,0,0,32'h100,0,          1,32'hDEADBEEF,0, 1,0,0,1,0, 32'h100,0,0));
    vecs.push_back(mk("ld_done",   1,0,0,32'h100,0,          0,0,0,            0,1,0,0,0, 0,0,32'hDEADBEEF));
    vecs.push_back(mk("ld_after",  0,0,0,0,0,                0,0,0,            0,0,0,0,0, 0,0,32'hDEADBEEF));
    vecs.push_back(mk("st_idle",   1,1,0,32'h204,0,          0,0,0,            1,0,0,0,0, 0,0,32'hDEADBEEF));
    vecs.push_back(mk("st_read",   1,1,0,32'h204,0,          1,32'h11223344,0, 1,0,0,1,0, 32'h204,0,32'hDEADBEEF));
    vecs.push_back(mk("st_merge",  1,1,0,32'h204,32'h11AA3344, 1,0,0,          1,0,0,0,0, 0,0,32'h11223344));
    vecs.push_back(mk("st_write",  1,1,0,32'h204,0,          1,0,0,            1,0,0,1,1, 32'h204,32'h11AA3344,32'h11223344));
    vecs.push_back(mk("st_done",   1,1,0,32'h204,0,          0,0,0,            0,1,0,0,0, 0,0,32'h11223344));
    vecs.push_back(mk("st_after",  0,0,0,0,0,                0,0,0,            0,0,0,0,0, 0,0,32'h11223344));
    vecs.push_back(mk("ws_idle",   1,0,0,32'h308,0,          0,0,0,            1,0,0,0,0, 0,0,32'h11223344));
    vecs.push_back(mk("ws_wait1",  1,0,0,32'hFFFFFFFC,0,     0,0,0,            1,0,0,1,0, 32'h308,0,32'h11223344));
    vecs.push_back(mk("ws_wait2",  1,0,0,32'hFFFFFFFC,0,     0,0,0,            1,0,0,1,0, 32'h308,0,32'h11223344));
    vecs.push_back(mk("ws_wait3",  1,0,0,32'hFFFFFFFC,0,     0,0,0,            1,0,0,1,0, 32'h308,0,32'h11223344));
    vecs.push_back(mk("ws_ready",  1,0,0,32'h308,0,          1,32'hCAFEF00D,0, 1,0,0,1,0, 32'h308,0,32'h11223344));
    vecs.push_back(mk("ws_done",   1,0,0,32'h308,0,          0,0,0,            0,1,0,0,0, 0,0,32'hCAFEF00D));
    vecs.push_back(mk("ws_after",  0,0,0,0,0,                0,0,0,            0,0,0,0,0, 0,0,32'hCAFEF00D));
    vecs.push_back(mk("flt_idle",  1,0,1,32'h102,0,          0,0,0,            1,0,0,0,0, 0,0,32'hCAFEF00D));
    vecs.push_back(mk("flt_pulse", 1,0,1,32'h102,0,          1,0,0,            0,1,1,0,0, 0,0,32'hCAFEF00D));
    vecs.push_back(mk("flt_after", 0,0,0,0,0,                0,0,0,            0,0,0,0,0, 0,0,32'hCAFEF00D));
    vecs.push_back(mk("be_idle",   1,1,0,32'h40C,0,          0,0,0,            1,0,0,0,0, 0,0,32'hCAFEF00D));
    vecs.push_back(mk("be_read",   1,1,0,32'h40C,0,          1,32'h12345678,1, 1,0,0,1,0, 32'h40C,0,32'hCAFEF00D));
    vecs.push_back(mk("be_done",   1,1,0,32'h40C,0,          0,0,0,            0,1,1,0,0, 0,0,32'h12345678));
    vecs.push_back(mk("be_after",  0,0,0,0,0,                0,0,0,            0,0,0,0,0, 0,0,32'h12345678));

    // Reset state with idle inputs.
    rst = 1'b1;
    req = 0; we_in = 0; fault_in = 0; addr_in = 0; wdata_in = 0;
    bus_ready = 0; bus_rdata = 0; bus_err = 0;
    #12;
    checkOutput(mk("reset_state", 0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0));
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven cycles: drive after the edge, check at the falling edge.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i]);
      @(posedge clk); #1;
    end

    // Read timeout: bus never ready, valid must last exactly 4 cycles.
    req = 1; we_in = 0; fault_in = 0; addr_in = 32'h500; bus_ready = 0; bus_err = 0;
    valid_cycles = 0; seen_done = 0; done_err = 0; addr_stable = 1;
    for (int k = 0; k < 20 && !seen_done; k++) begin
      @(negedge clk);
      if (bus_valid === 1'b1) begin
        valid_cycles++;
        if (bus_addr !== 32'h500) addr_stable = 0;
      end
      if (done === 1'b1) begin
        seen_done = 1;
        done_err  = err;
      end
    end
    checkValue("timeout_done_seen", 32'(seen_done), 32'd1);
    checkValue("timeout_valid_cycles", 32'(valid_cycles), 32'd4);
    checkValue("timeout_err", 32'(done_err), 32'd1);
    checkValue("timeout_addr_stable", 32'(addr_stable), 32'd1);
    checkValue("timeout_rdata_kept", rdata_out, 32'h12345678);
    @(posedge clk); #1;
    req = 0;
    @(negedge clk);
    checkValue("timeout_idle_busy", 32'(busy), 32'd0);

    // Store interrupted by reset during its write phase.
    @(posedge clk); #1;
    req = 1; we_in = 1; addr_in = 32'h600; bus_ready = 0;
    @(posedge clk); #1;
    bus_ready = 1; bus_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    bus_ready = 0; wdata_in = 32'h0BAD0000;
    @(posedge clk); #1;
    @(negedge clk);
    checkValue("rst_write_valid_before", {30'd0, bus_valid, bus_we}, 32'd3);
    checkValue("rst_write_wdata_before", bus_wdata, 32'h0BAD0000);
    #1 rst = 1'b1;
    #1;
    checkValue("rst_write_valid_now", 32'(bus_valid), 32'd0);
    checkValue("rst_write_busy_now", 32'(busy), 32'd0);
    checkValue("rst_write_wdata_now", bus_wdata, 32'd0);
    checkValue("rst_write_rdata_now", rdata_out, 32'd0);
    req = 0; we_in = 0;
    @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    done_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 1'b0) done_pulses++;
    end
    checkValue("rst_no_done", 32'(done_pulses), 32'd0);

    // Clean load after reset.
    @(posedge clk); #1;
    req = 1; we_in = 0; addr_in = 32'h700; bus_ready = 1; bus_rdata = 32'h77777777;
    @(negedge clk);
    checkValue("post_rst_idle", {29'd0, busy, bus_valid, done}, 32'd4);
    @(posedge clk); #1;
    @(negedge clk);
    checkValue("post_rst_read", {31'd0, bus_valid & ~bus_we}, 32'd1);
    checkValue("post_rst_addr", bus_addr, 32'h700);
    @(posedge clk); #1;
    bus_ready = 0;
    @(negedge clk);
    checkValue("post_rst_done", {30'd0, done, err}, 32'd2);
    checkValue("post_rst_rdata", rdata_out, 32'h77777777);
    @(posedge clk); #1;
    req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
